// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - fetch unit bus bundle: redirect, instruction memory and core handover
interface inst_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_misalign;
  logic        inst_ready;
  logic [31:0] fetch_count;

  // fetch unit side
  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc, inst_misalign, fetch_count
  );

  // core / memory side
  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, inst_misalign, fetch_count
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch unit with redirect and misalignment fault
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic      clk,
  input  logic      rst,
  inst_fetch_if.master bus
);

  // REQ: issuing, WAIT: granted awaiting data, HOLD: presenting, DROP: discarding a stale response
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_pc;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_misalign_q;
  logic [31:0] fetch_count_q;
  logic        aligned;

  assign aligned = (fetch_pc[1:0] == 2'b00);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  // next-state: redirect has priority; a granted-but-redirected request must have its data dropped
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (bus.redirect_valid)  state_nxt = (aligned && bus.imem_gnt) ? S_DROP : S_REQ;
        else if (!aligned)       state_nxt = S_HOLD;
        else if (bus.imem_gnt)   state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect_valid)  state_nxt = bus.imem_rvalid ? S_REQ : S_DROP;
        else if (bus.imem_rvalid) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.inst_ready || bus.redirect_valid) state_nxt = S_REQ;
      end
      S_DROP: begin
        if (bus.imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // memory request: only from REQ with an aligned pc; address always tracks fetch_pc
  always_comb begin
    bus.imem_req  = !rst && (state == S_REQ) && aligned;
    bus.imem_addr = fetch_pc;
  end

  // fetch pc, presented instruction and handover counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc        <= RESET_PC;
      inst_valid_q    <= 1'b0;
      inst_q          <= 32'h0;
      inst_pc_q       <= 32'h0;
      inst_misalign_q <= 1'b0;
      fetch_count_q   <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
          end else if (!aligned) begin
            inst_valid_q    <= 1'b1;
            inst_q          <= NOP_INST;
            inst_pc_q       <= fetch_pc;
            inst_misalign_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
          end else if (bus.imem_rvalid) begin
            inst_valid_q    <= 1'b1;
            inst_q          <= bus.imem_rdata;
            inst_pc_q       <= fetch_pc;
            inst_misalign_q <= 1'b0;
          end
        end
        S_HOLD: begin
          if (bus.inst_ready) begin
            inst_valid_q  <= 1'b0;
            fetch_count_q <= fetch_count_q + 32'd1;
            fetch_pc      <= bus.redirect_valid ? bus.redirect_pc : fetch_pc + 32'd4;
          end else if (bus.redirect_valid) begin
            inst_valid_q <= 1'b0;
            fetch_pc     <= bus.redirect_pc;
          end
        end
        S_DROP: begin
          if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
        end
        default: ;
      endcase
    end
  end

  assign bus.inst_valid    = inst_valid_q;
  assign bus.inst          = inst_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.inst_misalign = inst_misalign_q;
  assign bus.fetch_count   = fetch_count_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h80000000, first fetch address after reset.
REQ-002 Parameter: NOP_INST, 32'h00000013, instruction word presented with a misalignment fault.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 redirect_valid  in  1  core requests fetch from a new PC (branch/jump target).
REQ-006 redirect_pc  in  32  new fetch address; sampled when redirect_valid=1.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  32  request address; equals fetch_pc while imem_req=1.
REQ-009 imem_gnt  in  1  memory accepted the request this cycle.
REQ-010 imem_rvalid  in  1  read data valid; at most one per granted request, at least 1 cycle after gnt.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 inst_valid  out  1  inst/inst_pc/inst_misalign hold a valid fetched instruction.
REQ-013 inst  out  32  fetched instruction word (feeds the core's inst input).
REQ-014 inst_pc  out  32  address the instruction was fetched from.
REQ-015 inst_misalign  out  1  instruction address fault, fetch_pc[1:0]!=0.
REQ-016 inst_ready  in  1  core consumes the presented instruction this cycle.
REQ-017 fetch_count  out  32  number of instructions handed over (valid&&ready), wraps modulo 2^32.

Function
REQ-018 States: REQ, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-019 REQ: if fetch_pc[1:0]==0 drive imem_req=1, imem_addr=fetch_pc; on imem_gnt -> WAIT; no gnt -> stay REQ with address stable.
REQ-020 REQ with fetch_pc[1:0]!=0: imem_req=0; next cycle inst_valid=1, inst=NOP_INST, inst_pc=fetch_pc, inst_misalign=1; -> HOLD.
REQ-021 WAIT: on imem_rvalid register inst=imem_rdata, inst_pc=fetch_pc, inst_misalign=0, inst_valid=1 -> HOLD; minimum request-to-valid latency 2 cycles (gnt cycle, rvalid cycle, valid next edge).
REQ-022 HOLD: outputs stable while inst_ready=0; on inst_ready: inst_valid=0, fetch_pc<=fetch_pc+4 (32-bit wrap, 32'hFFFFFFFC -> 0), fetch_count+1, -> REQ.
REQ-023 inst_valid=1 only in HOLD; outputs are registered, no combinational path from imem_rdata or inst_ready to any output.
REQ-024 redirect_valid in REQ without gnt, or in HOLD: fetch_pc<=redirect_pc, inst_valid<=0, -> REQ.
REQ-025 redirect_valid in REQ with same-cycle imem_gnt (old address granted), or in WAIT without rvalid: fetch_pc<=redirect_pc, -> DROP.
REQ-026 redirect_valid in WAIT with same-cycle imem_rvalid: data discarded, fetch_pc<=redirect_pc, -> REQ.
REQ-027 DROP: imem_req=0; the stale rvalid is discarded (no inst_valid); on rvalid -> REQ; redirect in DROP updates fetch_pc, stays DROP unless rvalid same cycle (-> REQ).
REQ-028 redirect_valid with inst_ready in HOLD: handshake completes (fetch_count+1), next fetch_pc=redirect_pc, not +4.
REQ-029 imem_gnt/imem_rvalid outside the states expecting them are ignored.

Reset
REQ-030 While rst=1 (asynchronously on assertion): state=REQ, fetch_pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_misalign=0, fetch_count=0, imem_req=0.
REQ-031 First imem_req=1 with imem_addr=RESET_PC in the first cycle after rst deasserts; reset mid-transaction abandons any outstanding request, a late rvalid after reset is ignored only in DROP-equivalent sense: memory shall be reset together with this block.

Verification
REQ-032 Reset release, gnt same cycle, rvalid next cycle with 32'h00100093, ready=1 -> inst_valid with inst=32'h00100093, inst_pc=32'h80000000; next imem_addr=32'h80000004; fetch_count=1.
REQ-033 inst_ready held 0 for 5 cycles in HOLD -> inst/inst_pc/inst_valid unchanged, imem_req=0, fetch_count unchanged.
REQ-034 Redirect to 32'h80000100 while in WAIT, stale rvalid with 32'hDEADBEEF 3 cycles later -> DEADBEEF never presented; next request address 32'h80000100.
REQ-035 Redirect to 32'h80000102 -> no imem_req; inst_valid=1, inst=32'h00000013, inst_misalign=1, inst_pc=32'h80000102.
REQ-036 gnt withheld 4 cycles -> imem_req=1, imem_addr stable across all 4 cycles; single rvalid yields exactly one inst_valid.
REQ-037 rst asserted mid-WAIT -> outputs immediately at REQ-030 values; fetch restarts at 32'h80000000.
